// File: rtl/cv32e40p_apu_int_resp_if.sv
// APU request/grant/rvalid bundle between the core (master) and an APU responder (slave).
// Operand, op and flag widths follow the core's APU parameters.
interface cv32e40p_apu_int_resp_if #(
    parameter int APU_NARGS_CPU    = 3,
    parameter int APU_WOP_CPU      = 6,
    parameter int APU_NUSFLAGS_CPU = 5
);
    logic                               apu_req;
    logic                               apu_gnt;
    logic [APU_NARGS_CPU-1:0][31:0]     apu_operands;
    logic [APU_WOP_CPU-1:0]             apu_op;
    logic [14:0]                        apu_req_flags;
    logic                               apu_rvalid;
    logic [31:0]                        apu_result;
    logic [APU_NUSFLAGS_CPU-1:0]        apu_resp_flags;

    modport master (
        output apu_req, apu_operands, apu_op, apu_req_flags,
        input  apu_gnt, apu_rvalid, apu_result, apu_resp_flags
    );

    modport slave (
        input  apu_req, apu_operands, apu_op, apu_req_flags,
        output apu_gnt, apu_rvalid, apu_result, apu_resp_flags
    );
endinterface

// File: rtl/cv32e40p_apu_int_resp.sv
// Integer APU responder: ALU, pipelined multiply and iterative unsigned divide, with
// in-order collision-free responses enforced purely by the grant decision.
module cv32e40p_apu_int_resp #(
    parameter int APU_NARGS_CPU    = 3,
    parameter int APU_WOP_CPU      = 6,
    parameter int APU_NUSFLAGS_CPU = 5,
    parameter int MUL_LAT          = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    cv32e40p_apu_int_resp_if.slave    bus,
    output logic                      busy_o
);

    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;

    typedef struct packed {
        logic                        valid;
        logic [31:0]                 result;
        logic [APU_NUSFLAGS_CPU-1:0] flags;
    } resp_t;

    localparam logic [5:0] LAT_FAST = 6'd1;
    localparam logic [5:0] LAT_MUL  = 6'(MUL_LAT);
    localparam logic [5:0] LAT_DIV  = 6'd33;

    // r_q: cycles from now until the youngest in-flight response fires
    logic [5:0]               r_q, r_d;
    resp_t [MUL_LAT-1:0]      pend_q, pend_d;

    div_state_e               div_state_q, div_state_d;
    logic [31:0]              quo_q, quo_d;
    logic [31:0]              rem_q, rem_d;
    logic [31:0]              dvs_q, dvs_d;
    logic [4:0]               cnt_q, cnt_d;
    logic                     dz_q, dz_d;

    logic [31:0]              op_a, op_b;
    logic                     illegal, is_mul, is_div, gnt;
    logic [5:0]               lat;
    logic [63:0]              prod;
    resp_t                    new_resp;
    logic [32:0]              rem_sh, diff;
    logic                     div_done;
    logic [APU_NUSFLAGS_CPU-1:0] div_flags;

    // Decode, single-cycle datapath and grant decision
    // NOTE: every variable gets a default at the top of an always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        op_a     = bus.apu_operands[0];
        op_b     = bus.apu_operands[1];
        illegal  = |bus.apu_op[APU_WOP_CPU-1:3];
        is_mul   = !illegal && (bus.apu_op[2:0] == 3'd5 || bus.apu_op[2:0] == 3'd6);
        is_div   = !illegal && (bus.apu_op[2:0] == 3'd7);
        lat      = is_div ? LAT_DIV : (is_mul ? LAT_MUL : LAT_FAST);
        prod     = 64'(op_a) * 64'(op_b);
        new_resp       = '0;
        new_resp.valid = 1'b1;
        if (illegal) begin
            new_resp.flags[1] = 1'b1;
        end else begin
            case (bus.apu_op[2:0])
                3'd0:    new_resp.result = op_a + op_b;
                3'd1:    new_resp.result = op_a - op_b;
                3'd2:    new_resp.result = op_a & op_b;
                3'd3:    new_resp.result = op_a | op_b;
                3'd4:    new_resp.result = op_a ^ op_b;
                3'd5:    new_resp.result = prod[31:0];
                3'd6:    new_resp.result = prod[63:32];
                default: new_resp.result = '0;
            endcase
        end
        gnt = bus.apu_req && (lat > r_q) && (div_state_q != DIV_RUN);
    end

    // Response horizon and the fixed-latency delay line; slot i fires i+1 cycles from now
    always_comb begin
        r_d = (r_q == 6'd0) ? 6'd0 : r_q - 6'd1;
        if (gnt) r_d = lat - 6'd1;

        pend_d = '0;
        for (int i = 0; i < MUL_LAT - 1; i++) pend_d[i] = pend_q[i+1];
        if (gnt && is_mul)                pend_d[MUL_LAT-1] = new_resp;
        else if (gnt && !is_div)          pend_d[0]         = new_resp;
    end

    // Restoring divider: one quotient bit per RUN cycle, result presented in DONE
    always_comb begin
        div_state_d = div_state_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        dz_d        = dz_q;
        rem_sh      = {rem_q, quo_q[31]};
        diff        = rem_sh - {1'b0, dvs_q};
        case (div_state_q)
            DIV_RUN: begin
                if (!diff[32]) begin
                    rem_d = diff[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_sh[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) div_state_d = DIV_DONE;
            end
            DIV_DONE: div_state_d = DIV_IDLE;
            default:  ;
        endcase
        if (gnt && is_div) begin
            div_state_d = DIV_RUN;
            quo_d       = op_a;
            rem_d       = '0;
            dvs_d       = op_b;
            cnt_d       = '0;
            dz_d        = (op_b == '0);
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q         <= '0;
            // NOTE: the delay line is reset too: a stale valid bit would emit a phantom response.
            pend_q      <= '0;
            div_state_q <= DIV_IDLE;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            dz_q        <= 1'b0;
        end else begin
            r_q         <= r_d;
            pend_q      <= pend_d;
            div_state_q <= div_state_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            dz_q        <= dz_d;
        end
    end

    always_comb begin
        div_flags    = '0;
        div_flags[0] = dz_q;
    end

    assign div_done           = (div_state_q == DIV_DONE);
    assign bus.apu_gnt        = gnt;
    assign bus.apu_rvalid     = pend_q[0].valid | div_done;
    assign bus.apu_result     = pend_q[0].result | (div_done ? quo_q : 32'd0);
    assign bus.apu_resp_flags = pend_q[0].flags | (div_done ? div_flags : '0);
    assign busy_o             = (r_q != 6'd0);

    // Request flags and the third operand carry nothing for this coprocessor
    logic unused_ok;
    assign unused_ok = ^{bus.apu_req_flags, bus.apu_operands, rem_q[0]};

endmodule

// File: doc/cv32e40p_apu_int_resp.md
Name: cv32e40p_apu_int_resp

Overview:
- Responder end of the APU request/grant/rvalid interface. It is a small integer coprocessor attached to the core's APU port, used for offload bring-up and dispatcher verification.
- Accepts one request per cycle with a same-cycle grant, executes ALU, multiply or iterative unsigned-divide ops, and returns results strictly in order.
- Returns at most one rvalid pulse per cycle. The core has no response backpressure, so the block never stalls a response.

Parameters:
APU_NARGS_CPU, 3, number of 32-bit operands; only [0]=a and [1]=b are used, [2] is ignored
APU_WOP_CPU, 6, op field width
APU_NUSFLAGS_CPU, 5, response flag width
MUL_LAT, 2, grant-to-rvalid latency of MUL/MULHU, legal range 1..8, fully pipelined

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
apu_req_i  in  1  request valid
apu_gnt_o  out  1  grant; a transfer occurs when req and gnt are both high in the same cycle
apu_operands_i  in  APU_NARGS_CPU x 32  operands
apu_op_i  in  APU_WOP_CPU  operation
apu_flags_i  in  15  ignored
apu_rvalid_o  out  1  one-cycle result pulse
apu_result_o  out  32  result, valid while rvalid is high
apu_flags_o  out  APU_NUSFLAGS_CPU  bit0 divide-by-zero, bit1 illegal op, others 0
busy_o  out  1  at least one op in flight

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. At reset: apu_rvalid_o=0, apu_result_o=0, apu_flags_o=0, busy_o=0, all in-flight ops discarded.
- Reset asserted mid-operation: the in-flight op never produces rvalid.
- Op decode uses op[2:0] with op[5:3] required to be 0:
  - 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR: latency L=1.
  - 5 MUL (low 32 bits of a*b), 6 MULHU (high 32 bits, unsigned): L=MUL_LAT.
  - 7 DIVU (a/b unsigned): L=33, iterative, one divider.
  - op[5:3] != 0: illegal, L=1, result 0, flags bit1=1.
- Timing: an op granted in cycle t gives apu_rvalid_o=1 in cycle t+L exactly, for one cycle.
- In-order and collision rule: R(t) = cycles from t until the last in-flight rvalid, 0 if nothing is in flight.
  - apu_gnt_o = apu_req_i & (L(apu_op_i) > R(t)); gnt is combinational from req/op.
  - This guarantees in-order, collision-free responses.
  - A new op may be granted in the same cycle an older op's rvalid fires.
- Consequences of the rule:
  - A DIVU blocks all grants until its rvalid cycle.
  - A fast op directly behind a MUL is held until R < 1, i.e. R=0.
  - Back-to-back fast ops are granted every cycle. Back-to-back MULs are granted every cycle.
- Divide details:
  - Restoring algorithm, 32 iterations; operands captured at grant.
  - Divide by zero: result 0xFFFFFFFF, flags bit0=1.
- When the request is not granted, the core holds it; operands are sampled only at grant.
- apu_result_o and apu_flags_o are 0 whenever apu_rvalid_o=0.
- busy_o = (R(t) > 0).
- A gnt without req is allowed to be 0; gnt must never be 1 while req=0.

Test Plan:
- Reset release, idle, req=0 -> gnt=0, rvalid=0, busy=0 for all cycles.
- ADD a=5,b=7 granted at t, then SUB a=3,b=5 at t+1 -> rvalid at t+1 with 12, at t+2 with 0xFFFFFFFE.
- MUL_LAT=2: MUL 0x10000 x 0x10000 at t, then XOR req at t+1 -> XOR gnt=0 at t+1, gnt=1 at t+2. MUL rvalid at t+2 with 0x0. XOR rvalid at t+3.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> rvalid after MUL_LAT cycles with 0xFFFFFFFE.
- DIVU 100/7 at t -> gnt stays 0 for all requests t+1..t+32. rvalid at t+33 with 14, flags=0. A new ADD is granted at t+33.
- DIVU 9/0 -> result 0xFFFFFFFF, flags=0x01.
- op=6'b001000 -> result 0, flags=0x02 after 1 cycle.
- rst_n asserted at t+10 of a DIVU -> no rvalid ever, busy=0; a fresh ADD after reset is granted immediately.
